// File: rtl/nts_cookie_tx_pkg.sv
// Shared NTS cookie TX constants and FSM state type.
package nts_cookie_tx_pkg;

   localparam logic [15:0] NTP_TAG_NTS_COOKIE = 16'h0204;
   localparam logic [15:0] NTS_COOKIE_EXT_LEN = 16'h0068;
   localparam int unsigned NTS_COOKIE_BEATS   = 13;
   localparam logic [3:0]  LAST_BEAT          = 4'(NTS_COOKIE_BEATS - 1);

   typedef enum logic [1:0] {
      StIdle,
      StEmit,
      StDone
   } tx_state_e;

endpackage

// File: rtl/nts_cookie_tx_store.sv
// Word-indexed cookie register file with written-mask and 64-bit beat read port.
module nts_cookie_tx_store
   import nts_cookie_tx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        we_en,
   input  logic        clr,
   input  logic        keyid_we,
   input  logic        nonce_we,
   input  logic        tag_we,
   input  logic        c2s_we,
   input  logic        s2c_we,
   input  logic [2:0]  idx,
   input  logic [31:0] data,
   input  logic [3:0]  sel,
   output logic [63:0] beat,
   output logic        loaded
);

   logic [31:0]  keyid;
   logic [127:0] nonce;
   logic [127:0] tag;
   logic [255:0] c2s;
   logic [255:0] s2c;
   // bit 0 key ID, 1..4 nonce, 5..8 tag, 9..16 c2s, 17..24 s2c
   logic [24:0]  mask;

   logic [3:0]   fsel;
   logic         one_field;
   logic         short_ok;
   logic [1:0]   ridx_s;
   logic [2:0]   ridx_l;
   logic [4:0]   midx_s;
   logic [4:0]   midx_l;
   logic [831:0] full;
   logic [3:0]   rev;

   assign fsel      = {nonce_we, tag_we, c2s_we, s2c_we};
   assign one_field = (fsel != 4'b0) && ((fsel & (fsel - 4'd1)) == 4'b0);
   assign short_ok  = ~idx[2];
   // Word 0 is the most significant, so storage position is the reversed index.
   assign ridx_s    = ~idx[1:0];
   assign ridx_l    = ~idx;
   assign midx_s    = {3'b000, idx[1:0]};
   assign midx_l    = {2'b00, idx};
   assign loaded    = &mask;

   // Field word writes and written-mask tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         keyid <= '0;
         nonce <= '0;
         tag   <= '0;
         c2s   <= '0;
         s2c   <= '0;
         mask  <= '0;
      end else begin
         if (clr) begin
            mask <= '0;
         end
         if (we_en) begin
            if (keyid_we) begin
               keyid   <= data;
               mask[0] <= 1'b1;
            end
            if (one_field) begin
               if (nonce_we && short_ok) begin
                  nonce[{ridx_s, 5'b0} +: 32] <= data;
                  mask[5'd1 + midx_s]         <= 1'b1;
               end
               if (tag_we && short_ok) begin
                  tag[{ridx_s, 5'b0} +: 32] <= data;
                  mask[5'd5 + midx_s]       <= 1'b1;
               end
               if (c2s_we) begin
                  c2s[{ridx_l, 5'b0} +: 32] <= data;
                  mask[5'd9 + midx_l]       <= 1'b1;
               end
               if (s2c_we) begin
                  s2c[{ridx_l, 5'b0} +: 32] <= data;
                  mask[5'd17 + midx_l]      <= 1'b1;
               end
            end
         end
      end
   end

   assign full = {NTP_TAG_NTS_COOKIE, NTS_COOKIE_EXT_LEN, keyid, nonce, tag, c2s, s2c};
   assign rev  = LAST_BEAT - sel;

   // Beat select: beat 0 is the top 64 bits of the serialised field.
   always_comb begin
      beat = '0;
      if (sel <= LAST_BEAT) begin
         beat = full[{rev, 6'b0} +: 64];
      end
   end

endmodule

// File: rtl/nts_cookie_tx.sv
// NTS Cookie extension field serialiser: 13 x 64-bit beats over valid/ready.
module nts_cookie_tx
   import nts_cookie_tx_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_areset,
   input  logic        i_keyid_we,
   input  logic        i_nonce_we,
   input  logic        i_tag_we,
   input  logic        i_c2s_we,
   input  logic        i_s2c_we,
   input  logic [2:0]  i_word_index,
   input  logic [31:0] i_word_data,
   input  logic        i_start,
   output logic        o_busy,
   output logic        o_loaded,
   output logic        o_error,
   output logic        o_tx_valid,
   output logic [63:0] o_tx_data,
   output logic        o_tx_last,
   input  logic        i_tx_ready,
   output logic        o_done
);

   tx_state_e   state;
   logic [3:0]  cnt;
   logic [3:0]  sel;
   logic [63:0] beat;
   logic        loaded;

   // Prefetch the beat that will be presented after the next register update.
   assign sel      = (state == StEmit) ? cnt + 4'd1 : 4'd0;
   assign o_loaded = loaded;

   nts_cookie_tx_store u_store (
      .clk      (i_clk),
      .rst      (i_areset),
      .we_en    (state == StIdle),
      .clr      (state == StDone),
      .keyid_we (i_keyid_we),
      .nonce_we (i_nonce_we),
      .tag_we   (i_tag_we),
      .c2s_we   (i_c2s_we),
      .s2c_we   (i_s2c_we),
      .idx      (i_word_index),
      .data     (i_word_data),
      .sel      (sel),
      .beat     (beat),
      .loaded   (loaded)
   );

   // Emission FSM with registered handshake outputs.
   always_ff @(posedge i_clk) begin
      if (i_areset) begin
         state      <= StIdle;
         cnt        <= '0;
         o_busy     <= 1'b0;
         o_error    <= 1'b0;
         o_tx_valid <= 1'b0;
         o_tx_data  <= '0;
         o_tx_last  <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         o_error <= 1'b0;
         o_done  <= 1'b0;
         unique case (state)
            StIdle: begin
               if (i_start) begin
                  if (loaded) begin
                     state      <= StEmit;
                     cnt        <= '0;
                     o_busy     <= 1'b1;
                     o_tx_valid <= 1'b1;
                     o_tx_data  <= beat;
                     o_tx_last  <= 1'b0;
                  end else begin
                     o_error <= 1'b1;
                  end
               end
            end
            StEmit: begin
               if (o_tx_valid && i_tx_ready) begin
                  if (cnt == LAST_BEAT) begin
                     state      <= StDone;
                     o_busy     <= 1'b0;
                     o_tx_valid <= 1'b0;
                     o_tx_data  <= '0;
                     o_tx_last  <= 1'b0;
                     o_done     <= 1'b1;
                  end else begin
                     cnt       <= cnt + 4'd1;
                     o_tx_data <= beat;
                     o_tx_last <= (cnt + 4'd1 == LAST_BEAT);
                  end
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: doc/nts_cookie_tx.md
# nts_cookie_tx

Transmit-side counterpart of the cookie unwrap path. The block collects a wrapped NTS cookie (key ID, nonce, SIV tag, c2s and s2c ciphertext) as 32-bit words written by the cookie handler after a gencookie operation. On command it serialises the cookie as a complete NTS Cookie extension field, 832 bits long, into 13 64-bit beats for the TX buffer writer. A valid/ready handshake governs each beat.

## Interface
- EXT_TAG, 16'h0204, extension field type emitted in beat 0.
- EXT_LEN, 16'h0068, extension field length in bytes emitted in beat 0.
- i_clk  in  1  clock.
- i_areset  in  1  reset; one clock, synchronous, active-high.
- i_keyid_we  in  1  load i_word_data as the 32-bit master key ID.
- i_nonce_we, i_tag_we, i_c2s_we, i_s2c_we  in  1 each  select the field for the current word write; one-hot.
- i_word_index  in  3  word index within the field. Word 0 is the most significant and is sent first. Nonce and tag use 0..3; c2s and s2c use 0..7.
- i_word_data  in  32  write data.
- i_start  in  1  one-cycle pulse: begin emission.
- o_busy  out  1  emission in progress.
- o_loaded  out  1  all 25 words (key ID plus 24 payload words) written since the last clear.
- o_error  out  1  one-cycle pulse: i_start was rejected.
- o_tx_valid  out  1  beat valid.
- o_tx_data  out  64  beat data.
- o_tx_last  out  1  high with beat 12.
- i_tx_ready  in  1  sink accepts the beat when o_tx_valid and i_tx_ready are both high.
- o_done  out  1  one-cycle pulse the cycle after beat 12 is accepted.

## Operation
- Storage: keyid[31:0], nonce[127:0], tag[127:0], c2s[255:0], s2c[255:0].
- Storage has a 25-bit written-mask; o_loaded is the AND of the mask.
- Field word k maps to field[(N-1-k)*32 +: 32], where N is the field's word count.
- Writes are honoured only in IDLE. In EMIT they are ignored and the mask is unchanged.
- Out-of-range index: nonce or tag with index 4..7 is ignored.
- More than one field strobe high in the same cycle: the write is ignored.
- Beat layout follows {EXT_TAG, EXT_LEN, keyid, nonce, tag, c2s, s2c}, MSB first:
  - beat 0 = {EXT_TAG, EXT_LEN, keyid};
  - beats 1-2 = nonce;
  - beats 3-4 = tag;
  - beats 5-8 = c2s;
  - beats 9-12 = s2c.
- FSM states and transitions:
  - IDLE: i_start with o_loaded → EMIT, beat counter = 0. i_start without o_loaded → o_error pulse, stay in IDLE.
  - EMIT: o_tx_valid = 1. On acceptance the counter increments. Acceptance at counter 12 → DONE.
  - DONE: o_done = 1 for one cycle, clear the written-mask → IDLE. Storage contents are retained.
- i_start while busy is ignored and does not raise o_error.
- Beat counter is 4 bits, range 0..12, and never wraps past 12.

## Timing
- Reset values:
  - FSM = IDLE, counter = 0, mask = 0, storage = 0;
  - o_busy = 0, o_loaded = 0, o_error = 0, o_tx_valid = 0, o_tx_last = 0, o_done = 0;
  - o_tx_data = 64'h0.
- A word write is visible in o_loaded the next cycle.
- i_start accepted in cycle t: o_busy and o_tx_valid are high from t+1 with beat 0.
- With i_tx_ready held high: beats occupy t+1..t+13, o_done is high at t+14, and o_busy falls at t+14.
- Backpressure: with i_tx_ready low, o_tx_data, o_tx_valid and o_tx_last hold stable. o_tx_valid never drops once raised until the beat is accepted.
- o_tx_data and o_tx_last are registered. When o_tx_valid = 0, o_tx_data is 0.
- Reset mid-emission: next cycle is IDLE with all outputs at reset values. A partially sent field is abandoned; the sink is responsible for discarding it.

## Structure
- The shared NTS package holds:
  - NTP_TAG_NTS_COOKIE = 16'h0204;
  - NTS_COOKIE_EXT_LEN = 16'h0068;
  - NTS_COOKIE_BEATS = 13;
  - the FSM state enum.
- One sub-module, nts_cookie_tx_store: the word-indexed register file and written-mask, with a 4-bit beat-select read port returning the 64-bit beat. The top level holds the FSM and the handshake.

## Test plan
- Reset, then i_start with nothing loaded → o_error pulse; o_busy and o_tx_valid stay 0.
- Load key ID 32'h6c47f0d3 and the Testcase 1 cookie words, i_tx_ready = 1, pulse i_start. Required beats:
  - beat 0 = 64'h020400686c47f0d3;
  - beat 1 = 64'hcd65766f2c8fb4cc;
  - beat 3 = 64'ha507af99a998d839;
  - beat 12 = 64'h0efc99906cd3c2cb, with o_tx_last = 1;
  - o_done follows one cycle later.
- Same load, i_tx_ready toggled 1-0-0-1 pseudo-randomly → identical 13-beat sequence, o_tx_data stable while stalled, exactly 13 acceptances.
- Write c2s word 2 during EMIT → emitted data unchanged; after o_done, o_loaded = 0.
- Load all fields except s2c word 7 → o_loaded = 0 and i_start → o_error. Write the missing word → o_loaded = 1 next cycle.
- Assert i_areset at beat 6 → next cycle o_busy = 0, o_tx_valid = 0, o_loaded = 0, and a new full load emits correctly.
